// File: rtl/pipeline_controller_pkg.sv
// Shared types for the RV32I pipeline controller:
// opcodes, controller FSM states and stage-register enables.
package pipeline_controller_pkg;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [1:0] {
    RUN,
    WAIT_BOTH,
    WAIT_I,
    WAIT_D
  } ctrl_state_t;

  typedef struct packed {
    logic ld_pc;
    logic ld_if_id;
    logic ld_id_ex;
    logic ld_ex_mem;
    logic ld_mem_wb;
    logic fl_if_id;
    logic fl_id_ex;
  } pipe_ctrl_t;

endpackage

// File: rtl/pipeline_controller_if.sv
// Hazard, cache-handshake and enable bundle between
// the pipeline datapath and the stall/flush controller.
interface pipeline_controller_if
  import pipeline_controller_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  rv32i_opcode      ex_opcode;
  logic [4:0]       ex_rd;
  logic             br_taken;
  logic             icache_read;
  logic             icache_resp;
  logic             dcache_req;
  logic             dcache_resp;
  logic             load_pc;
  logic             load_if_id;
  logic             load_id_ex;
  logic             load_ex_mem;
  logic             load_mem_wb;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             i_resp_held;
  logic             d_resp_held;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] redirect_cnt;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_opcode, ex_rd, br_taken,
    output icache_read, icache_resp,
    output dcache_req, dcache_resp,
    input  load_pc, load_if_id, load_id_ex,
    input  load_ex_mem, load_mem_wb,
    input  flush_if_id, flush_id_ex,
    input  i_resp_held, d_resp_held,
    input  stall_cnt, bubble_cnt, redirect_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_opcode, ex_rd, br_taken,
    input  icache_read, icache_resp,
    input  dcache_req, dcache_resp,
    output load_pc, load_if_id, load_id_ex,
    output load_ex_mem, load_mem_wb,
    output flush_if_id, flush_id_ex,
    output i_resp_held, d_resp_held,
    output stall_cnt, bubble_cnt, redirect_cnt
  );
endinterface

// File: rtl/pipeline_controller_perf_counter.sv
// Enable-gated wrapping event counter used for
// the controller performance statistics.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (en)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer: freezes the pipe on cache misses,
// inserts load-use bubbles and flushes on EX redirects.
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic            clk,
  input logic            rst,
  pipeline_controller_if.slave bus
);

  ctrl_state_t state;
  ctrl_state_t nxt;
  logic        i_seen;
  logic        d_seen;
  logic        i_miss;
  logic        d_miss;
  logic        i_rsp;
  logic        d_rsp;
  logic        freeze;
  logic        load_use;
  logic        rs1_hit;
  logic        rs2_hit;
  pipe_ctrl_t  ctrl;

  assign i_rsp  = bus.icache_resp;
  assign d_rsp  = bus.dcache_resp;
  assign i_miss = bus.icache_read & ~i_rsp;
  assign d_miss = bus.dcache_req & ~d_rsp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= RUN;
    else
      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      RUN: begin
        if (i_miss && d_miss)
          nxt = WAIT_BOTH;
        else if (i_miss)
          nxt = WAIT_I;
        else if (d_miss)
          nxt = WAIT_D;
      end
      WAIT_BOTH: begin
        if (i_rsp && d_rsp)
          nxt = RUN;
        else if (i_rsp)
          nxt = WAIT_D;
        else if (d_rsp)
          nxt = WAIT_I;
      end
      WAIT_I: if (i_rsp) nxt = RUN;
      WAIT_D: if (d_rsp) nxt = RUN;
      default: nxt = RUN;
    endcase
  end

  // A half-served dual miss keeps the early response marked as
  // captured until the whole pipe is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_seen <= 1'b0;
      d_seen <= 1'b0;
    end else if (nxt == RUN) begin
      i_seen <= 1'b0;
      d_seen <= 1'b0;
    end else if (state == WAIT_BOTH) begin
      if (i_rsp) i_seen <= 1'b1;
      if (d_rsp) d_seen <= 1'b1;
    end
  end

  assign freeze  = (nxt != RUN);
  assign rs1_hit = bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd);
  assign rs2_hit = bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd);
  assign load_use = (bus.ex_opcode == op_load) &&
                    (bus.ex_rd != 5'd0) &&
                    (rs1_hit || rs2_hit);

  always_comb begin
    ctrl = '0;
    if (!rst && !freeze) begin
      if (bus.br_taken) begin
        ctrl = '1;
      end else if (load_use) begin
        ctrl.ld_id_ex  = 1'b1;
        ctrl.fl_id_ex  = 1'b1;
        ctrl.ld_ex_mem = 1'b1;
        ctrl.ld_mem_wb = 1'b1;
      end else begin
        ctrl.ld_pc     = 1'b1;
        ctrl.ld_if_id  = 1'b1;
        ctrl.ld_id_ex  = 1'b1;
        ctrl.ld_ex_mem = 1'b1;
        ctrl.ld_mem_wb = 1'b1;
      end
    end
  end

  assign bus.load_pc     = ctrl.ld_pc;
  assign bus.load_if_id  = ctrl.ld_if_id;
  assign bus.load_id_ex  = ctrl.ld_id_ex;
  assign bus.load_ex_mem = ctrl.ld_ex_mem;
  assign bus.load_mem_wb = ctrl.ld_mem_wb;
  assign bus.flush_if_id = ctrl.fl_if_id;
  assign bus.flush_id_ex = ctrl.fl_id_ex;
  assign bus.i_resp_held = i_seen;
  assign bus.d_resp_held = d_seen;

  perf_counter #(.CNT_W(CNT_W)) u_stall (
    .clk   (clk),
    .rst   (rst),
    .en    (freeze),
    .count (bus.stall_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_bubble (
    .clk   (clk),
    .rst   (rst),
    .en    (!freeze && !bus.br_taken && load_use),
    .count (bus.bubble_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_redirect (
    .clk   (clk),
    .rst   (rst),
    .en    (!freeze && bus.br_taken),
    .count (bus.redirect_cnt)
  );

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed and randomized check of pipeline_controller against
// a pending-request reference model.
module tb_pipeline_controller;
  import pipeline_controller_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipeline_controller_if #(.CNT_W(32)) bus ();

  pipeline_controller #(.CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // model: outstanding requests, held flags, counters
  bit          pi, pd, hi, hd;
  logic [31:0] sc, bc, rc;

  localparam logic [6:0] C_FRZ = 7'b00000_00;
  localparam logic [6:0] C_NRM = 7'b11111_00;
  localparam logic [6:0] C_BUB = 7'b00111_01;
  localparam logic [6:0] C_RED = 7'b11111_11;

  function automatic logic [6:0] dctrl();
    return {bus.load_pc, bus.load_if_id, bus.load_id_ex,
            bus.load_ex_mem, bus.load_mem_wb,
            bus.flush_if_id, bus.flush_id_ex};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.id_rs1      = 5'd0;
    bus.id_rs2      = 5'd0;
    bus.id_uses_rs1 = 1'b0;
    bus.id_uses_rs2 = 1'b0;
    bus.ex_opcode   = op_reg;
    bus.ex_rd       = 5'd0;
    bus.br_taken    = 1'b0;
    bus.icache_read = 1'b0;
    bus.icache_resp = 1'b0;
    bus.dcache_req  = 1'b0;
    bus.dcache_resp = 1'b0;
  endtask

  // One clock: model check mid-cycle, then advance model at the edge.
  task automatic tick();
    bit npi, npd, nhi, nhd, frz, lu, im, dm, br;
    logic [6:0] exp;
    #2;
    if (rst) begin
      pi = 0; pd = 0; hi = 0; hd = 0;
      sc = '0; bc = '0; rc = '0;
    end
    im = bus.icache_read && !bus.icache_resp;
    dm = bus.dcache_req && !bus.dcache_resp;
    br = bus.br_taken;
    if (!pi && !pd) begin
      npi = im;
      npd = dm;
    end else begin
      npi = pi && !bus.icache_resp;
      npd = pd && !bus.dcache_resp;
    end
    nhi = (hi || (pi && pd && bus.icache_resp)) && (npi || npd);
    nhd = (hd || (pi && pd && bus.dcache_resp)) && (npi || npd);
    frz = npi || npd;
    lu = (bus.ex_opcode == op_load) && (bus.ex_rd != 0) &&
         ((bus.id_uses_rs1 && bus.id_rs1 == bus.ex_rd) ||
          (bus.id_uses_rs2 && bus.id_rs2 == bus.ex_rd));
    if (rst || frz) exp = C_FRZ;
    else if (br)    exp = C_RED;
    else if (lu)    exp = C_BUB;
    else            exp = C_NRM;
    chk("ctrl", 32'(dctrl()), 32'(exp));
    chk("held", 32'({bus.i_resp_held, bus.d_resp_held}),
        32'({hi, hd}));
    chk("stall_cnt", bus.stall_cnt, sc);
    chk("bubble_cnt", bus.bubble_cnt, bc);
    chk("redirect_cnt", bus.redirect_cnt, rc);
    @(posedge clk);
    if (!rst) begin
      pi = npi; pd = npd; hi = nhi; hd = nhd;
      if (frz) sc++;
      if (!frz && !br && lu) bc++;
      if (!frz && br) rc++;
    end
    #1;
  endtask

  logic [31:0] s0, b0, r0;

  initial begin
    idle();
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // reset in the middle of a dual miss
    bus.icache_read = 1'b1;
    bus.dcache_req  = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_ctrl", 32'(dctrl()), 32'(C_FRZ));
    chk("rst_stall", bus.stall_cnt, 32'd0);
    tick();
    rst = 1'b0;
    idle();
    #1;
    chk("post_rst_ctrl", 32'(dctrl()), 32'(C_NRM));
    tick();

    // 3-cycle I-miss
    s0 = bus.stall_cnt;
    bus.icache_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("imiss_frz", 32'(dctrl()), 32'(C_FRZ));
      tick();
    end
    bus.icache_resp = 1'b1;
    #1;
    chk("imiss_rel", 32'(dctrl()), 32'(C_NRM));
    tick();
    idle();
    chk("imiss_stall", bus.stall_cnt - s0, 32'd3);

    // dual miss: D responds at cycle 1, I at cycle 4
    bus.icache_read = 1'b1;
    bus.dcache_req  = 1'b1;
    tick();
    bus.dcache_resp = 1'b1;
    tick();
    bus.dcache_req  = 1'b0;
    bus.dcache_resp = 1'b0;
    for (int i = 2; i < 5; i++) begin
      bus.icache_resp = (i == 4);
      #1;
      chk("dual_dheld", 32'(bus.d_resp_held), 32'd1);
      chk("dual_ctrl", 32'(dctrl()), 32'(i == 4 ? C_NRM : C_FRZ));
      tick();
    end
    idle();
    #1;
    chk("dual_dclr", 32'(bus.d_resp_held), 32'd0);
    tick();

    // load-use bubble
    b0 = bus.bubble_cnt;
    bus.ex_opcode   = op_load;
    bus.ex_rd       = 5'd5;
    bus.id_rs2      = 5'd5;
    bus.id_uses_rs2 = 1'b1;
    #1;
    chk("lu_ctrl", 32'(dctrl()), 32'(C_BUB));
    tick();
    chk("lu_bubble", bus.bubble_cnt - b0, 32'd1);
    bus.ex_rd  = 5'd0;
    bus.id_rs2 = 5'd0;
    #1;
    chk("lu_x0", 32'(dctrl()), 32'(C_NRM));
    tick();

    // redirect beats load-use
    b0 = bus.bubble_cnt;
    r0 = bus.redirect_cnt;
    bus.ex_rd    = 5'd5;
    bus.id_rs2   = 5'd5;
    bus.br_taken = 1'b1;
    #1;
    chk("br_lu_ctrl", 32'(dctrl()), 32'(C_RED));
    tick();
    chk("br_lu_red", bus.redirect_cnt - r0, 32'd1);
    chk("br_lu_bub", bus.bubble_cnt - b0, 32'd0);
    idle();

    // redirect held during a 2-cycle D-miss
    r0 = bus.redirect_cnt;
    bus.br_taken   = 1'b1;
    bus.dcache_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.dcache_resp = (i == 2);
      #1;
      chk("br_dm_ctrl", 32'(dctrl()), 32'(i == 2 ? C_RED : C_FRZ));
      tick();
    end
    chk("br_dm_red", bus.redirect_cnt - r0, 32'd1);
    idle();
    tick();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      bus.icache_read = $urandom_range(0, 1);
      bus.icache_resp = ($urandom_range(0, 2) == 0);
      bus.dcache_req  = ($urandom_range(0, 2) == 0);
      bus.dcache_resp = ($urandom_range(0, 2) == 0);
      bus.br_taken    = ($urandom_range(0, 4) == 0);
      bus.ex_opcode   = $urandom_range(0, 1) ? op_load : op_reg;
      bus.ex_rd       = 5'($urandom_range(0, 3));
      bus.id_rs1      = 5'($urandom_range(0, 3));
      bus.id_rs2      = 5'($urandom_range(0, 3));
      bus.id_uses_rs1 = $urandom_range(0, 1);
      bus.id_uses_rs2 = $urandom_range(0, 1);
      tick();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
